// File: rtl/snake_pkg.sv
// Shared definitions for the snake game controller.
// Holds the grid geometry, direction codes, the controller state enum,
// the power-up layout coordinates and small helpers that build that layout.
package snake_pkg;

  localparam int BLK_SIZE     = 32;
  localparam int GRID_COLS    = 45;
  localparam int GRID_ROWS    = 28;
  localparam int MAX_SEGMENTS = 23;
  localparam int COORD_W      = 11;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN,
    ST_UPDATE,
    ST_PLACE,
    ST_LOSE,
    ST_WIN
  } state_e;

  localparam logic [10:0] INIT_HEAD_X  = 11'd704;
  localparam logic [10:0] INIT_HEAD_Y  = 11'd448;
  localparam logic [10:0] INIT_APPLE_X = 11'd1024;
  localparam logic [10:0] INIT_APPLE_Y = 11'd448;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  // The starting snake lies horizontally, head rightmost, one cell per slot
  // trailing to the left; slots past the starting length are empty.
  function automatic logic [10:0] initSegX(int idx, int startLen, int blk);
    if (idx < startLen) return 11'(int'(INIT_HEAD_X) - idx * blk);
    return '0;
  endfunction

  function automatic logic [10:0] initSegY(int idx, int startLen);
    if (idx < startLen) return INIT_HEAD_Y;
    return '0;
  endfunction

  function automatic logic [1:0] initSegDir(int idx, int startLen);
    if (idx < startLen) return DIR_RIGHT;
    return DIR_UP;
  endfunction

endpackage

// File: rtl/snake_lfsr.sv
// Free-running pseudo-random source for apple placement.
// 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping every clock; seeded with
// a non-zero value on reset so it can never lock up at zero.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   colBits_o  - LFSR bits [5:0], raw column material
//   rowBits_o  - LFSR bits [12:8], raw row material
module snake_lfsr
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] colBits_o,
  output logic [4:0] rowBits_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift left, feeding back the XOR of the tap bits into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // The register advances on every clock regardless of game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign colBits_o = lfsr_q[5:0];
  assign rowBits_o = lfsr_q[12:8];

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller.
// Keeps the body as a shift array of cell positions, moves one cell per
// accepted step tick, checks walls and self-collision with a one-segment-per-
// cycle scan, grows on apples and places new apples on free cells using an
// LFSR. Positions, length and apple only change in single commit cycles.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   step_tick                 - one-cycle request for one move
//   btn_up/down/left/right    - one-cycle direction pulses
//   btn_start                 - leaves IDLE, or restarts after LOSE/WIN
//   snakepos_x/_y             - packed 11-bit pixel coordinates, slot 0 = head
//   length                    - number of live segments
//   direction                 - packed 2-bit heading per slot
//   applepos_x/_y             - apple top-left pixel
//   lose, win                 - game-end flags
module snake_ctrl #(
  parameter int BLK_SIZE     = snake_pkg::BLK_SIZE,
  parameter int MAX_SEGMENTS = snake_pkg::MAX_SEGMENTS,
  parameter int START_LEN    = 3,
  parameter int WIN_LEN      = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step_tick,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_start,
  output logic [11*MAX_SEGMENTS-1:0]  snakepos_x,
  output logic [11*MAX_SEGMENTS-1:0]  snakepos_y,
  output logic [5:0]                  length,
  output logic [53:0]                 direction,
  output logic [10:0]                 applepos_x,
  output logic [10:0]                 applepos_y,
  output logic                        lose,
  output logic                        win
);

  import snake_pkg::*;

  localparam int          IDX_W   = $clog2(MAX_SEGMENTS);
  localparam logic [11:0] STEP12  = 12'(BLK_SIZE);
  localparam logic [11:0] X_LIMIT = 12'((GRID_COLS - 1) * BLK_SIZE);
  localparam logic [11:0] Y_LIMIT = 12'((GRID_ROWS - 1) * BLK_SIZE);

  state_e state_q;
  state_e state_d;

  logic [10:0]      segX_q   [MAX_SEGMENTS];
  logic [10:0]      segY_q   [MAX_SEGMENTS];
  logic [1:0]       segDir_q [MAX_SEGMENTS];
  logic [5:0]       len_q;
  logic [10:0]      appleX_q;
  logic [10:0]      appleY_q;
  logic [1:0]       pendDir_q;
  logic [1:0]       moveDir_q;
  logic [10:0]      candX_q;
  logic [10:0]      candY_q;
  logic             eat_q;
  logic [IDX_W-1:0] idx_q;
  logic [10:0]      placeX_q;
  logic [10:0]      placeY_q;

  logic        btnValid;
  logic [1:0]  btnDir;
  logic        btnAccept;
  logic [11:0] nextX12;
  logic [11:0] nextY12;
  logic        offGrid;
  logic        nextEat;
  logic [5:0]  scanLimit;
  logic        scanHit;
  logic        scanDone;
  logic        placeHit;
  logic        placeLast;
  logic [5:0]  growLen;
  logic        reload;
  logic [5:0]  colBits;
  logic [4:0]  rowBits;
  logic [5:0]  colFix;
  logic [4:0]  rowFix;
  logic [10:0] sampleX;
  logic [10:0] sampleY;

  snake_lfsr uLfsr (
    .clk       (clk),
    .rst       (rst),
    .colBits_o (colBits),
    .rowBits_o (rowBits)
  );

  // Button arbitration: highest-priority pulse wins, and a reversal onto the
  // neck is dropped rather than falling through to a lower-priority button.
  always_comb begin
    btnValid = 1'b1;
    btnDir   = DIR_UP;
    if (btn_up) begin
      btnDir = DIR_UP;
    end else if (btn_down) begin
      btnDir = DIR_DOWN;
    end else if (btn_left) begin
      btnDir = DIR_LEFT;
    end else if (btn_right) begin
      btnDir = DIR_RIGHT;
    end else begin
      btnValid = 1'b0;
    end
    btnAccept = btnValid && (btnDir != (segDir_q[0] ^ 2'b10))
                && (state_q != ST_LOSE) && (state_q != ST_WIN);
  end

  // Candidate head one cell ahead. A 12-bit result lets a move off the top or
  // left edge underflow into a huge value that fails the limit check.
  always_comb begin
    nextX12 = {1'b0, segX_q[0]};
    nextY12 = {1'b0, segY_q[0]};
    case (pendDir_q)
      DIR_UP:    nextY12 = {1'b0, segY_q[0]} - STEP12;
      DIR_RIGHT: nextX12 = {1'b0, segX_q[0]} + STEP12;
      DIR_DOWN:  nextY12 = {1'b0, segY_q[0]} + STEP12;
      default:   nextX12 = {1'b0, segX_q[0]} - STEP12;
    endcase
    offGrid = (nextX12 > X_LIMIT) || (nextY12 > Y_LIMIT);
    nextEat = (nextX12[10:0] == appleX_q) && (nextY12[10:0] == appleY_q);
  end

  // Collision scan bookkeeping. Without eating, the tail vacates its cell in
  // the same move, so it is excluded from the scan.
  always_comb begin
    scanLimit = eat_q ? (len_q - 6'd1) : (len_q - 6'd2);
    scanHit   = (segX_q[idx_q] == candX_q) && (segY_q[idx_q] == candY_q);
    scanDone  = (6'(idx_q) == scanLimit);
    placeHit  = (segX_q[idx_q] == placeX_q) && (segY_q[idx_q] == placeY_q);
    placeLast = (6'(idx_q) == (len_q - 6'd1));
    growLen   = eat_q ? (len_q + 6'd1) : len_q;
    reload    = ((state_q == ST_LOSE) || (state_q == ST_WIN)) && btn_start;
  end

  // Fold LFSR bits into the grid range by a single conditional subtract.
  always_comb begin
    colFix  = (colBits >= 6'(GRID_COLS)) ? (colBits - 6'(GRID_COLS)) : colBits;
    rowFix  = (rowBits >= 5'(GRID_ROWS)) ? (rowBits - 5'(GRID_ROWS)) : rowBits;
    sampleX = 11'(int'(colFix) * BLK_SIZE);
    sampleY = 11'(int'(rowFix) * BLK_SIZE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step_tick) state_d = offGrid ? ST_LOSE : ST_SCAN;
      end
      ST_SCAN: begin
        if (scanHit) state_d = ST_LOSE;
        else if (scanDone) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (!eat_q) state_d = ST_RUN;
        else if ((len_q + 6'd1) == 6'(WIN_LEN)) state_d = ST_WIN;
        else state_d = ST_PLACE;
      end
      ST_PLACE: begin
        if (!placeHit && placeLast) state_d = ST_RUN;
      end
      ST_LOSE, ST_WIN: begin
        if (btn_start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output packing straight from the committed registers, so nothing in
  // flight inside SCAN or PLACE is ever visible.
  always_comb begin
    snakepos_x = '0;
    snakepos_y = '0;
    direction  = '0;
    for (int i = 0; i < MAX_SEGMENTS; i++) begin
      snakepos_x[11*i +: 11] = segX_q[i];
      snakepos_y[11*i +: 11] = segY_q[i];
      direction[2*i +: 2]    = segDir_q[i];
    end
    length     = len_q;
    applepos_x = appleX_q;
    applepos_y = appleY_q;
    lose       = (state_q == ST_LOSE);
    win        = (state_q == ST_WIN);
  end

  // Datapath: body array, apple, pending heading and scan/placement scratch.
  // The body moves as a whole in the UPDATE cycle; slots beyond the new
  // length are cleared so a dropped tail leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_SEGMENTS; i++) begin
        segX_q[i]   <= initSegX(i, START_LEN, BLK_SIZE);
        segY_q[i]   <= initSegY(i, START_LEN);
        segDir_q[i] <= initSegDir(i, START_LEN);
      end
      len_q     <= 6'(START_LEN);
      appleX_q  <= INIT_APPLE_X;
      appleY_q  <= INIT_APPLE_Y;
      pendDir_q <= DIR_RIGHT;
      moveDir_q <= DIR_RIGHT;
      candX_q   <= '0;
      candY_q   <= '0;
      eat_q     <= 1'b0;
      idx_q     <= '0;
      placeX_q  <= '0;
      placeY_q  <= '0;
    end else if (reload) begin
      for (int i = 0; i < MAX_SEGMENTS; i++) begin
        segX_q[i]   <= initSegX(i, START_LEN, BLK_SIZE);
        segY_q[i]   <= initSegY(i, START_LEN);
        segDir_q[i] <= initSegDir(i, START_LEN);
      end
      len_q     <= 6'(START_LEN);
      appleX_q  <= INIT_APPLE_X;
      appleY_q  <= INIT_APPLE_Y;
      pendDir_q <= DIR_RIGHT;
      eat_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (btnAccept) pendDir_q <= btnDir;
      case (state_q)
        ST_RUN: begin
          if (step_tick && !offGrid) begin
            candX_q   <= nextX12[10:0];
            candY_q   <= nextY12[10:0];
            eat_q     <= nextEat;
            moveDir_q <= pendDir_q;
            idx_q     <= '0;
          end
        end
        ST_SCAN: begin
          if (!scanDone) idx_q <= idx_q + IDX_W'(1);
        end
        ST_UPDATE: begin
          for (int i = 1; i < MAX_SEGMENTS; i++) begin
            if (6'(i) < growLen) begin
              segX_q[i]   <= segX_q[i-1];
              segY_q[i]   <= segY_q[i-1];
              segDir_q[i] <= segDir_q[i-1];
            end else begin
              segX_q[i]   <= '0;
              segY_q[i]   <= '0;
              segDir_q[i] <= DIR_UP;
            end
          end
          segX_q[0]   <= candX_q;
          segY_q[0]   <= candY_q;
          segDir_q[0] <= moveDir_q;
          len_q       <= growLen;
          placeX_q    <= sampleX;
          placeY_q    <= sampleY;
          idx_q       <= '0;
        end
        ST_PLACE: begin
          if (placeHit) begin
            placeX_q <= sampleX;
            placeY_q <= sampleY;
            idx_q    <= '0;
          end else if (placeLast) begin
            appleX_q <= placeX_q;
            appleY_q <= placeY_q;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed testbench for snake_ctrl: reset layout, start and stepping,
// button arbitration, eating, wall and self collision, win and restart,
// and reset in the middle of a collision scan.
module tb_snake_ctrl;

  import snake_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stepTick = 1'b0;
  logic          btnUp = 1'b0;
  logic          btnDown = 1'b0;
  logic          btnLeft = 1'b0;
  logic          btnRight = 1'b0;
  logic          btnStart = 1'b0;
  logic [252:0]  snakeX;
  logic [252:0]  snakeY;
  logic [5:0]    snakeLen;
  logic [53:0]   snakeDir;
  logic [10:0]   appleX;
  logic [10:0]   appleY;
  logic          loseFlag;
  logic          winFlag;

  int            checks = 0;
  int            passes = 0;
  logic [10:0]   forcedAppleX;
  logic [10:0]   forcedAppleY;

  snake_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (stepTick),
    .btn_up     (btnUp),
    .btn_down   (btnDown),
    .btn_left   (btnLeft),
    .btn_right  (btnRight),
    .btn_start  (btnStart),
    .snakepos_x (snakeX),
    .snakepos_y (snakeY),
    .length     (snakeLen),
    .direction  (snakeDir),
    .applepos_x (appleX),
    .applepos_y (appleY),
    .lose       (loseFlag),
    .win        (winFlag)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] segXAt(int i);
    return snakeX[11*i +: 11];
  endfunction

  function automatic logic [10:0] segYAt(int i);
    return snakeY[11*i +: 11];
  endfunction

  // Drive one cycle of pulses, centred on a rising edge.
  task automatic applyStimulus(input logic s, input logic u, input logic d,
                               input logic l, input logic r, input logic st);
    @(negedge clk);
    stepTick = s; btnUp = u; btnDown = d; btnLeft = l; btnRight = r; btnStart = st;
    @(negedge clk);
    stepTick = 0; btnUp = 0; btnDown = 0; btnLeft = 0; btnRight = 0; btnStart = 0;
  endtask

  task automatic waitSettled(input string name);
    bit done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (dut.state_q inside {ST_RUN, ST_LOSE, ST_WIN, ST_IDLE}) done = 1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL %s_timeout: state %0d still busy after 3000 cycles, expected RUN/LOSE/WIN", name, dut.state_q);
    end
  endtask

  task automatic doStep(input string name);
    applyStimulus(1, 0, 0, 0, 0, 0);
    waitSettled(name);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (segXAt(0) !== 11'd704 || segYAt(0) !== 11'd448) $display("[TB] FAIL reset_head: got (%0d,%0d), expected (704,448)", segXAt(0), segYAt(0));
    else passes++;
    checks++;
    if (segXAt(1) !== 11'd672 || segXAt(2) !== 11'd640 || segYAt(2) !== 11'd448) $display("[TB] FAIL reset_body: got x1=%0d x2=%0d y2=%0d, expected 672 640 448", segXAt(1), segXAt(2), segYAt(2));
    else passes++;
    checks++;
    if (segXAt(3) !== 11'd0 || segYAt(3) !== 11'd0) $display("[TB] FAIL reset_slot3: got (%0d,%0d), expected (0,0)", segXAt(3), segYAt(3));
    else passes++;
    checks++;
    if (snakeLen !== 6'd3) $display("[TB] FAIL reset_length: got %0d, expected 3", snakeLen);
    else passes++;
    checks++;
    if (snakeDir !== 54'h15) $display("[TB] FAIL reset_direction: got %h, expected 15", snakeDir);
    else passes++;
    checks++;
    if (appleX !== 11'd1024 || appleY !== 11'd448) $display("[TB] FAIL reset_apple: got (%0d,%0d), expected (1024,448)", appleX, appleY);
    else passes++;
    checks++;
    if (loseFlag !== 1'b0 || winFlag !== 1'b0) $display("[TB] FAIL reset_flags: got lose=%0b win=%0b, expected 0 0", loseFlag, winFlag);
    else passes++;
    // A step while idle must not move anything.
    applyStimulus(1, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (segXAt(0) !== 11'd704) $display("[TB] FAIL idle_step_ignored: got head x %0d, expected 704", segXAt(0));
    else passes++;
  endtask

  task automatic test_start_step();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    doStep("start_step");
    checks++;
    if (segXAt(0) !== 11'd736 || segYAt(0) !== 11'd448) $display("[TB] FAIL step_head: got (%0d,%0d), expected (736,448)", segXAt(0), segYAt(0));
    else passes++;
    checks++;
    if (segXAt(1) !== 11'd704 || segXAt(2) !== 11'd672 || segYAt(2) !== 11'd448) $display("[TB] FAIL step_body: got x1=%0d x2=%0d y2=%0d, expected 704 672 448", segXAt(1), segXAt(2), segYAt(2));
    else passes++;
    checks++;
    if (snakeLen !== 6'd3 || loseFlag !== 1'b0) $display("[TB] FAIL step_len_lose: got len=%0d lose=%0b, expected 3 0", snakeLen, loseFlag);
    else passes++;
  endtask

  task automatic test_buttons();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    doStep("btn_reverse");
    checks++;
    if (segXAt(0) !== 11'd736 || segYAt(0) !== 11'd448) $display("[TB] FAIL btn_reverse_ignored: got (%0d,%0d), expected (736,448)", segXAt(0), segYAt(0));
    else passes++;
    applyStimulus(0, 1, 0, 1, 0, 0);
    doStep("btn_priority");
    checks++;
    if (segXAt(0) !== 11'd736 || segYAt(0) !== 11'd416) $display("[TB] FAIL btn_priority_up: got (%0d,%0d), expected (736,416)", segXAt(0), segYAt(0));
    else passes++;
    checks++;
    if (snakeDir[5:0] !== 6'b010100) $display("[TB] FAIL btn_head_dir: got %b, expected 010100", snakeDir[5:0]);
    else passes++;
  endtask

  task automatic test_eat();
    logic [10:0] ax;
    logic [10:0] ay;
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) doStep("eat_walk");
    checks++;
    if (snakeLen !== 6'd4) $display("[TB] FAIL eat_length: got %0d, expected 4", snakeLen);
    else passes++;
    checks++;
    if (segXAt(0) !== 11'd1024 || segXAt(3) !== 11'd928 || segYAt(3) !== 11'd448) $display("[TB] FAIL eat_tail_kept: got head %0d slot3 (%0d,%0d), expected 1024 (928,448)", segXAt(0), segXAt(3), segYAt(3));
    else passes++;
    checks++;
    if (snakeDir[7:0] !== 8'h55) $display("[TB] FAIL eat_direction: got %h, expected 55", snakeDir[7:0]);
    else passes++;
    ax = appleX;
    ay = appleY;
    checks++;
    if (ax[4:0] !== 5'd0 || ay[4:0] !== 5'd0 || ax > 11'd1408 || ay > 11'd864) $display("[TB] FAIL eat_apple_on_grid: got (%0d,%0d), expected a cell inside 0..1408 x 0..864", ax, ay);
    else passes++;
    checks++;
    if (ay == 11'd448 && (ax == 11'd1024 || ax == 11'd992 || ax == 11'd960 || ax == 11'd928)) $display("[TB] FAIL eat_apple_free: got (%0d,%0d), expected a cell not under the snake", ax, ay);
    else passes++;
  endtask

  task automatic test_wall();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    doStep("wall_up");
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 22; k++) doStep("wall_walk");
    checks++;
    if (segXAt(0) !== 11'd1408 || segYAt(0) !== 11'd416 || loseFlag !== 1'b0) $display("[TB] FAIL wall_edge_reached: got (%0d,%0d) lose=%0b, expected (1408,416) 0", segXAt(0), segYAt(0), loseFlag);
    else passes++;
    doStep("wall_hit");
    checks++;
    if (loseFlag !== 1'b1 || winFlag !== 1'b0) $display("[TB] FAIL wall_lose: got lose=%0b win=%0b, expected 1 0", loseFlag, winFlag);
    else passes++;
    checks++;
    if (segXAt(0) !== 11'd1408 || segXAt(1) !== 11'd1376 || segXAt(2) !== 11'd1344 || segYAt(0) !== 11'd416 || snakeLen !== 6'd3) $display("[TB] FAIL wall_frozen: got x=%0d,%0d,%0d y0=%0d len=%0d, expected 1408,1376,1344 416 3", segXAt(0), segXAt(1), segXAt(2), segYAt(0), snakeLen);
    else passes++;
    doStep("wall_after");
    repeat (3) @(negedge clk);
    checks++;
    if (segXAt(0) !== 11'd1408 || loseFlag !== 1'b1) $display("[TB] FAIL wall_step_after_lose: got head x %0d lose=%0b, expected 1408 1", segXAt(0), loseFlag);
    else passes++;
  endtask

  task automatic test_self_collision();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) doStep("coll_walk");
    force dut.appleX_q = 11'd1056;
    force dut.appleY_q = 11'd448;
    doStep("coll_grow");
    checks++;
    if (snakeLen !== 6'd5 || segXAt(0) !== 11'd1056 || segXAt(4) !== 11'd928) $display("[TB] FAIL coll_length5: got len=%0d head=%0d tail=%0d, expected 5 1056 928", snakeLen, segXAt(0), segXAt(4));
    else passes++;
    applyStimulus(0, 1, 0, 0, 0, 0);
    doStep("coll_up");
    applyStimulus(0, 0, 0, 1, 0, 0);
    doStep("coll_left");
    checks++;
    if (loseFlag !== 1'b0 || segXAt(0) !== 11'd1024 || segYAt(0) !== 11'd416) $display("[TB] FAIL coll_before_down: got lose=%0b head (%0d,%0d), expected 0 (1024,416)", loseFlag, segXAt(0), segYAt(0));
    else passes++;
    applyStimulus(0, 0, 1, 0, 0, 0);
    doStep("coll_down");
    checks++;
    if (loseFlag !== 1'b1 || segXAt(0) !== 11'd1024 || segYAt(0) !== 11'd416 || snakeLen !== 6'd5) $display("[TB] FAIL coll_lose: got lose=%0b head (%0d,%0d) len=%0d, expected 1 (1024,416) 5", loseFlag, segXAt(0), segYAt(0), snakeLen);
    else passes++;
    release dut.appleX_q;
    release dut.appleY_q;
  endtask

  task automatic test_win_restart();
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    forcedAppleY = 11'd448;
    for (int k = 1; k <= 20; k++) begin
      forcedAppleX = 11'(704 + 32 * k);
      force dut.appleX_q = forcedAppleX;
      force dut.appleY_q = forcedAppleY;
      doStep("win_grow");
    end
    checks++;
    if (winFlag !== 1'b1 || loseFlag !== 1'b0) $display("[TB] FAIL win_flags: got win=%0b lose=%0b, expected 1 0", winFlag, loseFlag);
    else passes++;
    checks++;
    if (snakeLen !== 6'd23 || segXAt(0) !== 11'd1344 || segXAt(22) !== 11'd640) $display("[TB] FAIL win_body: got len=%0d head=%0d slot22=%0d, expected 23 1344 640", snakeLen, segXAt(0), segXAt(22));
    else passes++;
    release dut.appleX_q;
    release dut.appleY_q;
    applyStimulus(0, 0, 0, 0, 0, 1);
    checks++;
    if (segXAt(0) !== 11'd704 || segXAt(2) !== 11'd640 || segXAt(3) !== 11'd0 || segXAt(22) !== 11'd0 || snakeLen !== 6'd3) $display("[TB] FAIL restart_layout: got x0=%0d x2=%0d x3=%0d x22=%0d len=%0d, expected 704 640 0 0 3", segXAt(0), segXAt(2), segXAt(3), segXAt(22), snakeLen);
    else passes++;
    checks++;
    if (winFlag !== 1'b0 || loseFlag !== 1'b0 || appleX !== 11'd1024 || snakeDir !== 54'h15) $display("[TB] FAIL restart_flags_apple: got win=%0b lose=%0b apple x=%0d dir=%h, expected 0 0 1024 15", winFlag, loseFlag, appleX, snakeDir);
    else passes++;
    // Reset arriving mid-scan must discard the move in flight.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checks++;
    if (dut.state_q !== ST_SCAN) $display("[TB] FAIL rst_scan_entered: got state %0d, expected SCAN", dut.state_q);
    else passes++;
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (segXAt(0) !== 11'd704 || segXAt(1) !== 11'd672 || snakeLen !== 6'd3 || dut.state_q !== ST_IDLE) $display("[TB] FAIL rst_mid_scan: got x0=%0d x1=%0d len=%0d state=%0d, expected 704 672 3 IDLE", segXAt(0), segXAt(1), snakeLen, dut.state_q);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_start_step();
    test_buttons();
    test_eat();
    test_wall();
    test_self_collision();
    test_win_restart();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter BLK_SIZE, default 32: pixel pitch of one grid cell.
REQ-002 SHALL have parameter MAX_SEGMENTS, default 23: segment slots in the packed position buses.
REQ-003 SHALL have parameter START_LEN, default 3: snake length after reset or restart.
REQ-004 SHALL have parameter WIN_LEN, default 23: length that ends the game as a win.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port step_tick, input, 1 bit: one-cycle pulse requesting one game move.
REQ-008 SHALL have ports btn_up, btn_down, btn_left, btn_right, input, 1 bit each: debounced one-cycle pulses.
REQ-009 SHALL have port btn_start, input, 1 bit: one-cycle pulse that leaves IDLE, or restarts from LOSE/WIN.
REQ-010 SHALL have port snakepos_x, output, 253 bits: pixel x of segment i at [11*i +: 11]; i=0 is the head.
REQ-011 SHALL have port snakepos_y, output, 253 bits: same packing as snakepos_x, for pixel y.
REQ-012 SHALL have port length, output, 6 bits: number of live segments.
REQ-013 SHALL have port direction, output, 54 bits: 2-bit heading of segment i at [2*i +: 2]; bits [53:46] are 0.
REQ-014 SHALL have ports applepos_x and applepos_y, output, 11 bits each: apple top-left pixel.
REQ-015 SHALL have ports lose and win, output, 1 bit each: game-end flags.

Function
REQ-016 SHALL encode direction as 00 up, 01 right, 10 down, 11 left.
REQ-017 SHALL use a grid of 45 cols x 28 rows, with coordinate = cell*32: x in 0..1408, y in 0..864.
REQ-018 SHALL implement FSM states IDLE, RUN, SCAN, UPDATE, PLACE, LOSE, WIN.
REQ-019 SHALL hold the initial layout in IDLE, go IDLE->RUN on btn_start, and ignore step_tick in IDLE.
REQ-020 SHALL latch button pulses into a pending direction in every state except LOSE/WIN:
- same-cycle priority up>down>left>right;
- a pulse opposite the current head direction is ignored.
REQ-021 SHALL, on RUN with step_tick, form a candidate head = head ±32 on one axis per the pending direction, and set eat = (candidate == apple).
REQ-022 SHALL go straight to LOSE, with no scan, if the candidate leaves the grid; edge arithmetic is 12-bit so 0-32 is not mistaken for a wrap.
REQ-023 SHALL, in SCAN, compare the candidate to one segment per cycle:
- indices 0..length-2, or 0..length-1 when eat;
- any match -> LOSE; scan complete -> UPDATE.
REQ-024 SHALL, in UPDATE, commit in one cycle:
- slot i <- slot i-1 for i=1..MAX_SEGMENTS-1; head <- candidate; head direction <- pending;
- if eat, length+1 and the old tail is kept as the new last slot.
REQ-025 SHALL leave UPDATE as follows: eat and length == WIN_LEN -> WIN; eat otherwise -> PLACE; no eat -> RUN.
REQ-026 SHALL, in PLACE, each attempt:
- sample the LFSR: col = v[5:0], minus 45 if ≥45; row = v[12:8], minus 28 if ≥28;
- scan all live segments one per cycle; any hit -> resample; clear -> write apple, go RUN.
REQ-027 SHALL drop step_tick outside RUN, with no queueing.
REQ-028 SHALL change position, length and apple outputs only in single commit cycles; a partial shift is never visible.
REQ-029 SHALL hold 0 position and 00 direction in slots ≥ length.
REQ-030 SHALL, in LOSE/WIN:
- hold the respective flag at 1 and freeze all outputs;
- on btn_start, reload the initial layout, clear the flags and go to RUN.
REQ-031 SHALL never assert lose and win together.

Reset
REQ-032 SHALL, on rst (asynchronous), set:
- state IDLE, length START_LEN;
- head (704,448), seg1 (672,448), seg2 (640,448), all live directions 01, other slots 0;
- apple (1024,448), lose=win=0, pending direction 01, LFSR 16'hACE1.
REQ-033 SHALL abort SCAN/PLACE on rst mid-operation and leave only the reset layout.

Structure
REQ-034 SHALL place BLK_SIZE, GRID_COLS=45, GRID_ROWS=28, MAX_SEGMENTS, direction codes, the state enum and initial coordinates in shared package snake_pkg.
REQ-035 SHALL instantiate one sub-module, snake_lfsr:
- 16-bit Fibonacci LFSR, taps 16,14,13,11;
- advances every cycle; never reaches zero.

Verification
REQ-036 SHALL cover: reset, btn_start, one step_tick -> head (736,448), seg2 (672,448), length 3, lose 0.
REQ-037 SHALL cover button handling:
- btn_left while heading right, then step -> head (736,448);
- btn_up and btn_left in the same cycle, then step -> head y 416.
REQ-038 SHALL cover eating: step onto apple (1024,448) -> length 4, slot 3 = old tail, new apple on a free on-grid cell.
REQ-039 SHALL cover walls: head x=1408 heading right, step -> lose=1, positions unchanged; a later step_tick has no effect.
REQ-040 SHALL cover self-collision: length 5 straight right, then up, left, down steps -> lose=1 on the down step.
REQ-041 SHALL cover game end and reset:
- force apples until length 23 -> win=1, lose=0;
- btn_start -> initial layout, flags 0;
- rst during SCAN -> reset layout.
